// File: rtl/bcd_counter_latch_n_if.sv
// Control/read-out bundle between the gate controller/display scanner and the BCD counting core.
`timescale 1ns/1ps
interface bcd_counter_latch_n_if #(parameter int SEL_W = 3);
  logic             clk_enable;
  logic             reset_ctr;
  logic             latchit;
  logic             blank_en;
  logic [SEL_W-1:0] digit_select;
  logic [3:0]       digit_muxed;
  logic             carry_out;
  logic             overflow;
  logic             overflow_latched;
  logic             latch_valid;

  modport master (
    output clk_enable, reset_ctr, latchit, blank_en, digit_select,
    input  digit_muxed, carry_out, overflow, overflow_latched, latch_valid
  );

  modport slave (
    input  clk_enable, reset_ctr, latchit, blank_en, digit_select,
    output digit_muxed, carry_out, overflow, overflow_latched, latch_valid
  );
endinterface

// File: rtl/bcd_counter_latch_n.sv
// N-digit synchronous BCD event counter with edge-triggered capture latch,
// leading-zero blanking, sticky overflow and a combinational digit read-out mux.
`timescale 1ns/1ps
module bcd_counter_latch_n_digit (
  input  logic       clk_in,
  input  logic       nreset,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] val,
  output logic       is9
);
  logic [3:0] val_q, val_d;

  always_comb begin
    val_d = val_q;
    if (clr)      val_d = 4'd0;
    else if (inc) val_d = (val_q == 4'd9) ? 4'd0 : val_q + 4'd1;
  end

  always_ff @(posedge clk_in or negedge nreset)
    if (!nreset) val_q <= 4'd0;
    else         val_q <= val_d;

  assign val = val_q;
  assign is9 = (val_q == 4'd9);
endmodule

module bcd_counter_latch_n #(
  parameter int         DIGITS     = 8,
  parameter bit         SATURATE   = 1'b0,
  parameter logic [3:0] BLANK_CODE = 4'hF
) (
  input logic                clk_in,
  input logic                nreset,
  bcd_counter_latch_n_if.slave bus
);
  localparam int SEL_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [DIGITS-1:0][3:0] cnt;
  logic [DIGITS-1:0]      is9;
  logic [DIGITS:0]        low9;   // low9[k]: digits 0..k-1 all 9
  logic [DIGITS:0]        hi0;    // hi0[k]: digits k..DIGITS-1 all 0
  logic                   all9, hold, cap;
  logic [SEL_W-1:0]       sel;

  logic [DIGITS-1:0][3:0] latch_q, latch_d;
  logic                   latchit_q, ovf_q, ovf_d, ovl_q, ovl_d, lv_q;

  assign low9[0]      = 1'b1;
  assign hi0[DIGITS]  = 1'b1;
  assign all9         = low9[DIGITS];
  // Saturating build freezes the digits once every digit reads 9.
  assign hold         = SATURATE && all9;

  for (genvar k = 0; k < DIGITS; k++) begin : g_dig
    assign low9[k+1] = low9[k] & is9[k];
    assign hi0[k]    = hi0[k+1] & (cnt[k] == 4'd0);
    bcd_counter_latch_n_digit u_dig (
      .clk_in (clk_in),
      .nreset (nreset),
      .clr    (bus.reset_ctr),
      .inc    (bus.clk_enable & low9[k] & ~hold),
      .val    (cnt[k]),
      .is9    (is9[k])
    );
  end

  assign cap = bus.latchit & ~latchit_q;

  always_comb begin
    latch_d = latch_q;
    ovl_d   = ovl_q;
    ovf_d   = ovf_q;
    if (cap) begin
      ovl_d = ovf_q;
      for (int k = 0; k < DIGITS; k++)
        latch_d[k] = (bus.blank_en && k != 0 && hi0[k]) ? BLANK_CODE : cnt[k];
    end
    if (bus.reset_ctr)                  ovf_d = 1'b0;
    else if (bus.clk_enable && all9)    ovf_d = 1'b1;
  end

  always_ff @(posedge clk_in or negedge nreset) begin
    if (!nreset) begin
      for (int k = 0; k < DIGITS; k++)
        latch_q[k] <= (k == 0) ? 4'd0 : BLANK_CODE;
      latchit_q <= 1'b0;
      ovf_q     <= 1'b0;
      ovl_q     <= 1'b0;
      lv_q      <= 1'b0;
    end else begin
      latch_q   <= latch_d;
      latchit_q <= bus.latchit;
      ovf_q     <= ovf_d;
      ovl_q     <= ovl_d;
      lv_q      <= cap;
    end
  end

  assign sel = bus.digit_select;

  always_comb begin
    bus.digit_muxed = BLANK_CODE;
    if (int'(sel) < DIGITS) bus.digit_muxed = latch_q[sel];
  end

  assign bus.carry_out        = bus.clk_enable & all9;
  assign bus.overflow         = ovf_q;
  assign bus.overflow_latched = ovl_q;
  assign bus.latch_valid      = lv_q;
endmodule

// File: tb/tb_bcd_counter_latch_n.sv
// Bench: three cores (4-digit wrap, 4-digit saturate, 5-digit wrap) share one stimulus
// stream and are compared against an arithmetic reference model every cycle.
`timescale 1ns/1ps
module tb_bcd_counter_latch_n;
  logic clk = 1'b0, nreset = 1'b0;
  logic en = 1'b0, rc = 1'b0, lt = 1'b0, bl = 1'b0;
  logic [2:0] sel = 3'd0;
  int errors = 0, checks = 0;

  always #10 clk = ~clk;

  bcd_counter_latch_n_if #(.SEL_W(2)) if_w ();
  bcd_counter_latch_n_if #(.SEL_W(2)) if_s ();
  bcd_counter_latch_n_if #(.SEL_W(3)) if_5 ();

  assign if_w.clk_enable = en;  assign if_s.clk_enable = en;  assign if_5.clk_enable = en;
  assign if_w.reset_ctr  = rc;  assign if_s.reset_ctr  = rc;  assign if_5.reset_ctr  = rc;
  assign if_w.latchit    = lt;  assign if_s.latchit    = lt;  assign if_5.latchit    = lt;
  assign if_w.blank_en   = bl;  assign if_s.blank_en   = bl;  assign if_5.blank_en   = bl;
  assign if_w.digit_select = sel[1:0];
  assign if_s.digit_select = sel[1:0];
  assign if_5.digit_select = sel;

  bcd_counter_latch_n #(.DIGITS(4), .SATURATE(1'b0), .BLANK_CODE(4'hF))
    u_w (.clk_in(clk), .nreset(nreset), .bus(if_w));
  bcd_counter_latch_n #(.DIGITS(4), .SATURATE(1'b1), .BLANK_CODE(4'hF))
    u_s (.clk_in(clk), .nreset(nreset), .bus(if_s));
  bcd_counter_latch_n #(.DIGITS(5), .SATURATE(1'b0), .BLANK_CODE(4'hF))
    u_5 (.clk_in(clk), .nreset(nreset), .bus(if_5));

  logic [3:0] o_dig [3];
  logic       o_co [3], o_ov [3], o_ol [3], o_lv [3];
  assign o_dig[0] = if_w.digit_muxed; assign o_dig[1] = if_s.digit_muxed; assign o_dig[2] = if_5.digit_muxed;
  assign o_co[0] = if_w.carry_out;    assign o_co[1] = if_s.carry_out;    assign o_co[2] = if_5.carry_out;
  assign o_ov[0] = if_w.overflow;     assign o_ov[1] = if_s.overflow;     assign o_ov[2] = if_5.overflow;
  assign o_ol[0] = if_w.overflow_latched; assign o_ol[1] = if_s.overflow_latched; assign o_ol[2] = if_5.overflow_latched;
  assign o_lv[0] = if_w.latch_valid;  assign o_lv[1] = if_s.latch_valid;  assign o_lv[2] = if_5.latch_valid;

  function automatic int maxv(int d); return (d == 2) ? 100000 : 10000; endfunction
  function automatic int ndig(int d); return (d == 2) ? 5 : 4; endfunction
  function automatic bit satv(int d); return d == 1; endfunction

  // Reference model: counts held as plain integers, latch held as (value, blank flag).
  int m_cnt [3], m_lat [3];
  bit m_ov [3], m_ol [3];
  bit m_blk, m_lv, m_prev;

  always @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int d = 0; d < 3; d++) begin
        m_cnt[d] <= 0; m_lat[d] <= 0; m_ov[d] <= 1'b0; m_ol[d] <= 1'b0;
      end
      m_blk <= 1'b1; m_lv <= 1'b0; m_prev <= 1'b0;
    end else begin
      m_lv   <= lt && !m_prev;
      m_prev <= lt;
      if (lt && !m_prev) m_blk <= bl;
      for (int d = 0; d < 3; d++) begin
        if (lt && !m_prev) begin
          m_lat[d] <= m_cnt[d];
          m_ol[d]  <= m_ov[d];
        end
        if (rc) begin
          m_cnt[d] <= 0; m_ov[d] <= 1'b0;
        end else if (en) begin
          if (m_cnt[d] == maxv(d) - 1) begin
            m_ov[d]  <= 1'b1;
            m_cnt[d] <= satv(d) ? m_cnt[d] : 0;
          end else m_cnt[d] <= m_cnt[d] + 1;
        end
      end
    end
  end

  function automatic logic [3:0] exp_dig(int val, bit blk, int k, int n);
    int p = 1;
    int q;
    if (k >= n) return 4'hF;
    for (int i = 0; i < k; i++) p = p * 10;
    q = val / p;
    if (k >= 1 && blk && q == 0) return 4'hF;
    return 4'(q % 10);
  endfunction

  task automatic chk(string tag, int d, logic [3:0] obs, logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d observed=%h expected=%h", tag, d, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("%s.carry", tag), d, {3'd0, o_co[d]}, {3'd0, en && (m_cnt[d] == maxv(d) - 1)});
      chk($sformatf("%s.ovf", tag),   d, {3'd0, o_ov[d]}, {3'd0, m_ov[d]});
      chk($sformatf("%s.ovl", tag),   d, {3'd0, o_ol[d]}, {3'd0, m_ol[d]});
      chk($sformatf("%s.lv", tag),    d, {3'd0, o_lv[d]}, {3'd0, m_lv});
    end
    for (int s = 0; s < 8; s++) begin
      sel = 3'(s);
      #1;
      for (int d = 0; d < 3; d++)
        if (d == 2 || s < 4)
          chk($sformatf("%s.dig%0d", tag, s), d, o_dig[d], exp_dig(m_lat[d], m_blk, s, ndig(d)));
    end
  endtask

  task automatic tick(string tag, int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      check_all(tag);
    end
  endtask

  task automatic chk_sel(string tag, int d, int s, logic [3:0] exp);
    sel = 3'(s);
    #1;
    chk(tag, d, o_dig[d], exp);
  endtask

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    check_all("reset");
    nreset = 1'b1;

    // 1234 events, blanked capture
    en = 1'b1; tick("cnt1234", 1234);
    en = 1'b0; lt = 1'b1; bl = 1'b1; tick("cap1234", 1);
    lt = 1'b0; tick("lv1234", 1);
    chk_sel("read1234.d0", 0, 0, 4'd4);
    chk_sel("read1234.d3", 0, 3, 4'd1);

    // 7 events: blanked vs straight copy, out-of-range select on 5 digits
    rc = 1'b1; tick("clr7", 1); rc = 1'b0;
    en = 1'b1; tick("cnt7", 7);
    en = 1'b0; lt = 1'b1; bl = 1'b1; tick("cap7b", 1);
    lt = 1'b0; tick("gap7", 1);
    chk_sel("read7b.d1", 0, 1, 4'hF);
    lt = 1'b1; bl = 1'b0; tick("cap7n", 1);
    lt = 1'b0; tick("post7n", 1);
    chk_sel("read7n.d1", 0, 1, 4'd0);
    chk_sel("read7n.sel5", 2, 5, 4'hF);

    // overflow: wrap vs saturate
    rc = 1'b1; tick("clrovf", 1); rc = 1'b0;
    en = 1'b1; tick("cnt10001", 10001);
    en = 1'b0; lt = 1'b1; bl = 1'b1; tick("capovf", 1);
    lt = 1'b0; en = 1'b1; tick("satmore", 4);
    en = 1'b0; rc = 1'b1; tick("clrafterovf", 1);
    rc = 1'b0; tick("idle", 1);

    // capture + count + clear on the same edge, then latchit held high
    rc = 1'b1; tick("clr41", 1); rc = 1'b0;
    en = 1'b1; tick("cnt41", 41);
    lt = 1'b1; rc = 1'b1; tick("capclr", 1);
    rc = 1'b0; tick("holdlt", 20);
    chk_sel("read41.d0", 0, 0, 4'd1);
    chk_sel("read41.d1", 0, 1, 4'd4);
    lt = 1'b0; en = 1'b0; tick("rel", 2);

    // async reset mid-count with 0567 latched
    rc = 1'b1; tick("clr567", 1); rc = 1'b0;
    en = 1'b1; tick("cnt567", 567);
    en = 1'b0; lt = 1'b1; bl = 1'b1; tick("cap567", 1);
    lt = 1'b0; en = 1'b1; tick("midcnt", 30);
    nreset = 1'b0;
    #1;
    check_all("async");
    tick("inrst", 2);
    nreset = 1'b1;
    tick("resume", 50);

    // randomized traffic
    repeat (3000) begin
      en = ($urandom_range(0, 9) < 8);
      lt = ($urandom_range(0, 3) == 0);
      bl = 1'($urandom_range(0, 1));
      rc = ($urandom_range(0, 99) == 0);
      tick("rand", 1);
    end
    en = 1'b0; lt = 1'b0; rc = 1'b0;
    tick("final", 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bcd_counter_latch_n.md
Name: bcd_counter_latch_n

Overview:
Parametrised N-digit synchronous BCD event counter with a capture latch, optional leading-zero blanking, overflow detection and a multiplexed digit read-out. It is the next-generation counting core of the frequency counter. Count events arrive as a clock enable on clk_in. The gate controller issues capture and clear. The display scanner reads one latched digit per cycle via digit_select.

Parameters:
DIGITS, 8, number of BCD digits (2..16); SEL_W = max(1, $clog2(DIGITS)) is a derived localparam.
SATURATE, 0, 0 = wrap to all zeros after all-9s; 1 = hold at all-9s once overflowed.
BLANK_CODE, 4'hF, nibble substituted for a blanked digit and returned for an out-of-range select.

Ports:
clk_in  input  1  single clock; all state on its rising edge
nreset  input  1  asynchronous active-low reset
clk_enable  input  1  count event: increment by 1 on this edge
reset_ctr  input  1  synchronous clear of count digits and live overflow
latchit  input  1  capture request; its rising level (0->1 between samples) triggers one capture
blank_en  input  1  1 = blank leading zeros at capture time
digit_select  input  SEL_W  latched digit index for read-out, 0 = LSD
digit_muxed  output  4  latched digit[digit_select], combinational
carry_out  output  1  1 when clk_enable=1 and all digits = 9 (combinational)
overflow  output  1  live sticky overflow of running count
overflow_latched  output  1  overflow value captured with the last latch
latch_valid  output  1  one-cycle pulse the cycle after a capture

Behaviour:
- Async reset (nreset=0):
  - all count digits = 0; overflow = 0; overflow_latched = 0; latch_valid = 0; capture edge detector = 0.
  - latch digits 1..DIGITS-1 = BLANK_CODE; latch digit 0 = 0 (display reads "0").
- Counting:
  - digit k increments when clk_enable=1 and digits 0..k-1 are all 9.
  - A digit at 9 rolls to 0 and passes the carry on. Digits never leave 0..9.
- Overflow:
  - When clk_enable=1 and all digits = 9:
    - overflow <= 1 (sticky until reset_ctr or nreset).
    - SATURATE=0: all digits -> 0. SATURATE=1: digits hold at 9.
  - With SATURATE=1, every further enable while saturated keeps the digits at 9 and asserts carry_out.
- Clear:
  - reset_ctr=1 clears digits and overflow on the same edge with no extra latency.
  - Clear has priority over a simultaneous clk_enable.
  - Latch contents and overflow_latched are untouched by reset_ctr.
- Capture:
  - Registered latchit_d tracks latchit. A capture occurs on an edge where latchit=1 and latchit_d=0.
  - Holding latchit high gives exactly one capture. A new capture requires latchit to return to 0 for at least one cycle.
  - The latch takes the pre-edge counter state, i.e. the value before any simultaneous increment or clear on that edge. This holds for capture+count and capture+clear in the same cycle.
  - overflow_latched <= overflow (pre-edge value).
  - latch_valid = 1 on the cycle following the capture edge, otherwise 0.
- Blanking, computed at capture:
  - If blank_en=1: latch digit k (k>=1) = BLANK_CODE when digits k..DIGITS-1 are all 0; otherwise the digit value.
  - Digit 0 is never blanked.
  - If blank_en=0: straight copy.
  - blank_en is sampled only on the capture edge.
- Read-out:
  - digit_muxed = latch[digit_select], zero-cycle combinational path.
  - digit_select >= DIGITS returns BLANK_CODE.
- No X propagation: all flops reset. No latches (level-sensitive storage) are inferred.

Test Plan:
1. DIGITS=4, reset, then 1234 enables, pulse latchit, blank_en=1 -> latch_valid one cycle later; selects 0..3 read 4,3,2,1; overflow_latched=0.
2. DIGITS=4, 7 enables, blank_en=1, capture -> selects read 7,F,F,F; repeat with blank_en=0 -> 7,0,0,0; select 5 (SEL_W=2 forbids, use DIGITS=5) -> F.
3. DIGITS=4, SATURATE=0, 10001 enables -> carry_out pulses on the 10000th enable; count = 0001; overflow=1. Capture -> 1,F,F,F with overflow_latched=1. reset_ctr -> overflow=0, overflow_latched stays 1.
4. DIGITS=4, SATURATE=1, 10005 enables -> count holds 9999; overflow=1; carry_out asserted on each enable from the 10000th.
5. Count at 0041: assert clk_enable, latchit rising and reset_ctr in the same cycle -> latch reads 1,4,F,F (pre-edge); count = 0000 next cycle. Hold latchit high 20 cycles while counting -> no second latch_valid.
6. nreset low mid-count with latch holding 0567 -> immediate digits 0, latch reads 0,F,F,F, all flags 0; release and resume counting from 0.
